// File: rtl/nfc_copy_engine_if.sv
// Job-control interface of the NAND-flash page copy engine.
//   start      : one-cycle request to begin a copy job
//   first_page : first page address of the job
//   page_cnt   : number of pages to copy (0 completes immediately)
//   busy       : job in progress
//   done       : last job finished; held until the next accepted start
// master = job requester, slave = copy engine.
interface nfc_copy_engine_if #(
  parameter int PAGE_W = 9
);
  logic              start;
  logic [PAGE_W-1:0] first_page;
  logic [PAGE_W:0]   page_cnt;
  logic              busy;
  logic              done;

  modport master (output start, first_page, page_cnt, input busy, done);
  modport slave  (input start, first_page, page_cnt, output busy, done);
endinterface

// File: rtl/nfc_copy_engine.sv
// NAND-flash page copy engine: copies a run of pages from flash A to the same
// page addresses on flash B, one byte at a time through a byte register.
// Ports:
//   clk, rst           : clock (rising edge) and synchronous active-high reset
//   job (slave)        : start / first_page / page_cnt in, busy / done out
//   F_IO_A, F_IO_B     : 8-bit bidirectional flash buses (A source, B dest)
//   F_CLE_x, F_ALE_x   : command / address latch enables
//   F_REN_x, F_WEN_x   : active-low read / write strobes
//   F_RB_x             : flash ready (1) / busy (0)
// Every strobe is one cycle low then one cycle high with IO/CLE/ALE held for
// both cycles. A strobe is only started while the channel's R/B is high; the
// strobe sequencer simply stalls in its low-phase slot until it is.
module nfc_copy_engine #(
  parameter int PAGE_BYTES = 512,
  parameter int PAGE_W     = 9,
  parameter int RB_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  nfc_copy_engine_if.slave job,
  inout  wire  [7:0]       F_IO_A,
  output logic             F_CLE_A,
  output logic             F_ALE_A,
  output logic             F_REN_A,
  output logic             F_WEN_A,
  input  logic             F_RB_A,
  inout  wire  [7:0]       F_IO_B,
  output logic             F_CLE_B,
  output logic             F_ALE_B,
  output logic             F_REN_B,
  output logic             F_WEN_B,
  input  logic             F_RB_B
);

  localparam int CNT_W = $clog2(PAGE_BYTES + 1);
  localparam int TMR_W = $clog2(RB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAGE_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(RB_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, A_CMD, A_ADDR, A_WAIT, B_CMD, B_ADDR, COPY, B_PROG, B_WAIT, NEXT, DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]        ph;          // strobe phase; 0..1 for writes, 0..3 in COPY
  logic [1:0]        addr_idx;    // which of the three address bytes
  logic [CNT_W-1:0]  byte_cnt;
  logic [PAGE_W:0]   pages_left;
  logic [TMR_W-1:0]  rb_timer;
  logic              seen_low;    // R/B low observed during the current wait
  logic [PAGE_W-1:0] page_addr;
  logic [7:0]        byte_reg;

  logic        rb_ch;
  logic        wait_exit;
  logic        last_byte;
  logic [15:0] page16;
  logic [7:0]  addr_byte;

  logic       io_a_oe, io_b_oe;
  logic [7:0] io_a_out, io_b_out;

  assign F_IO_A = io_a_oe ? io_a_out : 8'bz;
  assign F_IO_B = io_b_oe ? io_b_out : 8'bz;

  assign last_byte = (byte_cnt == LAST_BYTE);
  assign page16    = 16'(page_addr);

  always_comb begin
    case (addr_idx)
      2'd0:    addr_byte = 8'h00;
      2'd1:    addr_byte = page16[7:0];
      default: addr_byte = page16[15:8];
    endcase
  end

  // R/B of the channel the current state talks to.
  always_comb begin
    case (state)
      A_CMD, A_ADDR, A_WAIT, COPY: rb_ch = F_RB_A;
      default:                     rb_ch = F_RB_B;
    endcase
  end

  // A wait ends once R/B went low and came back high, or when R/B never
  // dropped within RB_TIMEOUT cycles (device assumed already ready).
  assign wait_exit = seen_low ? rb_ch : (rb_ch && (rb_timer == TMR_LAST));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (job.start) state_nx = (job.page_cnt == '0) ? DONE : A_CMD;
      A_CMD:   if (ph == 2'd1) state_nx = A_ADDR;
      A_ADDR:  if (ph == 2'd1 && addr_idx == 2'd2) state_nx = A_WAIT;
      A_WAIT:  if (wait_exit) state_nx = B_CMD;
      B_CMD:   if (ph == 2'd1) state_nx = B_ADDR;
      B_ADDR:  if (ph == 2'd1 && addr_idx == 2'd2) state_nx = COPY;
      COPY:    if (ph == 2'd3 && last_byte) state_nx = B_PROG;
      B_PROG:  if (ph == 2'd1) state_nx = B_WAIT;
      B_WAIT:  if (wait_exit) state_nx = NEXT;
      NEXT:    state_nx = (pages_left == (PAGE_W+1)'(1)) ? DONE : A_CMD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    F_CLE_A  = 1'b0;
    F_ALE_A  = 1'b0;
    F_REN_A  = 1'b1;
    F_WEN_A  = 1'b1;
    F_CLE_B  = 1'b0;
    F_ALE_B  = 1'b0;
    F_REN_B  = 1'b1;
    F_WEN_B  = 1'b1;
    io_a_oe  = 1'b0;
    io_a_out = 8'h00;
    io_b_oe  = 1'b0;
    io_b_out = 8'h00;
    case (state)
      A_CMD: begin
        io_a_oe  = 1'b1;
        io_a_out = 8'h00;
        F_CLE_A  = 1'b1;
        F_WEN_A  = !(ph == 2'd0 && F_RB_A);
      end
      A_ADDR: begin
        io_a_oe  = 1'b1;
        io_a_out = addr_byte;
        F_ALE_A  = 1'b1;
        F_WEN_A  = !(ph == 2'd0 && F_RB_A);
      end
      B_CMD: begin
        io_b_oe  = 1'b1;
        io_b_out = 8'h80;
        F_CLE_B  = 1'b1;
        F_WEN_B  = !(ph == 2'd0 && F_RB_B);
      end
      B_ADDR: begin
        io_b_oe  = 1'b1;
        io_b_out = addr_byte;
        F_ALE_B  = 1'b1;
        F_WEN_B  = !(ph == 2'd0 && F_RB_B);
      end
      COPY: begin
        F_REN_A = !(ph == 2'd0 && F_RB_A);
        if (ph[1]) begin
          io_b_oe  = 1'b1;
          io_b_out = byte_reg;
          F_WEN_B  = !(ph == 2'd2 && F_RB_B);
        end
      end
      B_PROG: begin
        io_b_oe  = 1'b1;
        io_b_out = 8'h10;
        F_CLE_B  = 1'b1;
        F_WEN_B  = !(ph == 2'd0 && F_RB_B);
      end
      default: ;
    endcase
  end

  // Control counters and job status
  always_ff @(posedge clk) begin
    if (rst) begin
      ph         <= 2'd0;
      addr_idx   <= 2'd0;
      byte_cnt   <= '0;
      pages_left <= '0;
      rb_timer   <= '0;
      seen_low   <= 1'b0;
      job.busy   <= 1'b0;
      job.done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ph       <= 2'd0;
          addr_idx <= 2'd0;
          byte_cnt <= '0;
          rb_timer <= '0;
          seen_low <= 1'b0;
          if (job.start) begin
            pages_left <= job.page_cnt;
            job.busy   <= (job.page_cnt != '0);
            job.done   <= 1'b0;
          end
        end
        A_CMD, B_CMD, B_PROG: begin
          if (ph == 2'd0) begin
            if (rb_ch) ph <= 2'd1;
          end else begin
            ph <= 2'd0;
          end
        end
        A_ADDR, B_ADDR: begin
          if (ph == 2'd0) begin
            if (rb_ch) ph <= 2'd1;
          end else begin
            ph       <= 2'd0;
            addr_idx <= (addr_idx == 2'd2) ? 2'd0 : addr_idx + 2'd1;
          end
        end
        A_WAIT, B_WAIT: begin
          if (wait_exit) begin
            rb_timer <= '0;
            seen_low <= 1'b0;
          end else if (!seen_low) begin
            if (!rb_ch) seen_low <= 1'b1;
            rb_timer <= rb_timer + 1'b1;
          end
        end
        COPY: begin
          case (ph)
            2'd0: if (F_RB_A) ph <= 2'd1;
            2'd1: ph <= 2'd2;
            2'd2: if (F_RB_B) ph <= 2'd3;
            default: begin
              ph       <= 2'd0;
              byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            end
          endcase
        end
        NEXT: pages_left <= pages_left - 1'b1;
        default: ;
      endcase
      if (state_nx == DONE && state != DONE) begin
        job.busy <= 1'b0;
        job.done <= 1'b1;
      end
    end
  end

  // Page address and byte register carry data only
  always_ff @(posedge clk) begin
    if (state == IDLE && job.start) page_addr <= job.first_page;
    else if (state == NEXT)         page_addr <= page_addr + 1'b1;
    if (state == COPY && ph == 2'd1) byte_reg <= F_IO_A;
  end

endmodule

// File: tb/tb_nfc_copy_engine.sv
module tb_nfc_copy_engine;
  localparam int PAGE_BYTES = 512;
  localparam int PAGE_W     = 9;
  localparam int RB_TIMEOUT = 64;
  localparam int B_PER_PAGE = 1 + 3 + PAGE_BYTES + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nfc_copy_engine_if #(.PAGE_W(PAGE_W)) job ();

  wire  [7:0] f_io_a, f_io_b;
  logic f_cle_a, f_ale_a, f_ren_a, f_wen_a;
  logic f_cle_b, f_ale_b, f_ren_b, f_wen_b;
  logic rb_a = 1'b1;
  logic rb_b = 1'b1;

  nfc_copy_engine #(
    .PAGE_BYTES(PAGE_BYTES), .PAGE_W(PAGE_W), .RB_TIMEOUT(RB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .job(job),
    .F_IO_A(f_io_a), .F_CLE_A(f_cle_a), .F_ALE_A(f_ale_a),
    .F_REN_A(f_ren_a), .F_WEN_A(f_wen_a), .F_RB_A(rb_a),
    .F_IO_B(f_io_b), .F_CLE_B(f_cle_b), .F_ALE_B(f_ale_b),
    .F_REN_B(f_ren_b), .F_WEN_B(f_wen_b), .F_RB_B(rb_b)
  );

  function automatic logic [7:0] pat(input int p, input int i);
    return 8'((p * 13 + i * 7 + 3) % 256);
  endfunction

  // Flash A model: outputs read data whenever the engine is not latching a
  // command or address into it; data for byte n appears after the n-th REN low.
  logic [15:0] a_page = 16'h0;
  int          a_rd_cnt = 0;
  logic [7:0]  a_rd_data;
  always_comb a_rd_data = pat(int'(a_page), a_rd_cnt - 1);
  assign f_io_a = (!f_cle_a && !f_ale_a) ? a_rd_data : 8'bz;

  logic [9:0] a_log[$];
  logic [9:0] b_log[$];
  int ren_a_n = 0;
  int cyc = 0, a3_cyc = 0, b80_cyc = 0, b10_cyc = 0;
  int a_addr_n = 0, a_left = 0, b_left = 0;
  logic a_arm = 1'b0, b_arm = 1'b0;
  int rb_a_busy, rb_b_busy;
  logic prev_wen_a = 1'b1, prev_wen_b = 1'b1, prev_ren_a = 1'b1, prev_rst = 1'b1;
  logic [9:0] prev_bus_a = '0, prev_bus_b = '0;
  int shape_a = 0, shape_b = 0, rbv_a = 0, rbv_b = 0;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_rst   <= rst;
    prev_wen_a <= f_wen_a;
    prev_wen_b <= f_wen_b;
    prev_ren_a <= f_ren_a;
    prev_bus_a <= {f_cle_a, f_ale_a, f_io_a};
    prev_bus_b <= {f_cle_b, f_ale_b, f_io_b};
    if (!prev_rst && !prev_wen_a && (!f_wen_a || {f_cle_a, f_ale_a, f_io_a} != prev_bus_a))
      shape_a <= shape_a + 1;
    if (!prev_rst && !prev_wen_b && (!f_wen_b || {f_cle_b, f_ale_b, f_io_b} != prev_bus_b))
      shape_b <= shape_b + 1;
    if (!prev_rst && !prev_ren_a && !f_ren_a) shape_a <= shape_a + 1;
    if ((!f_wen_a || !f_ren_a) && !rb_a) rbv_a <= rbv_a + 1;
    if ((!f_wen_b || !f_ren_b) && !rb_b) rbv_b <= rbv_b + 1;

    if (!f_wen_a) begin
      a_log.push_back({f_cle_a, f_ale_a, f_io_a});
      if (f_cle_a) begin
        a_addr_n <= 0;
        a_rd_cnt <= 0;
      end else if (f_ale_a) begin
        if (a_addr_n == 1) a_page[7:0] <= f_io_a;
        if (a_addr_n == 2) begin
          a_page[15:8] <= f_io_a;
          a3_cyc       <= cyc;
          a_arm        <= 1'b1;
        end
        a_addr_n <= a_addr_n + 1;
      end
    end
    if (!f_ren_a) begin
      a_rd_cnt <= a_rd_cnt + 1;
      ren_a_n  <= ren_a_n + 1;
    end
    if (!f_wen_b) begin
      b_log.push_back({f_cle_b, f_ale_b, f_io_b});
      if (f_cle_b && f_io_b == 8'h80) b80_cyc <= cyc;
      if (f_cle_b && f_io_b == 8'h10) begin
        b10_cyc <= cyc;
        b_arm   <= 1'b1;
      end
    end

    // R/B drops in the cycle after the triggering strobe's low phase.
    if (a_arm) begin
      a_arm <= 1'b0;
      if (rb_a_busy > 0) begin
        rb_a   <= 1'b0;
        a_left <= rb_a_busy;
      end
    end else if (!rb_a) begin
      a_left <= a_left - 1;
      if (a_left <= 1) rb_a <= 1'b1;
    end
    if (b_arm) begin
      b_arm <= 1'b0;
      if (rb_b_busy > 0) begin
        rb_b   <= 1'b0;
        b_left <= rb_b_busy;
      end
    end else if (!rb_b) begin
      b_left <= b_left - 1;
      if (b_left <= 1) rb_b <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ent(input logic c, input logic a, input logic [7:0] d);
    return {c, a, d};
  endfunction

  function automatic int miss_a(input int idx, input logic [9:0] e);
    if (idx >= a_log.size()) return 1;
    return (a_log[idx] !== e) ? 1 : 0;
  endfunction

  function automatic int miss_b(input int idx, input logic [9:0] e);
    if (idx >= b_log.size()) return 1;
    return (b_log[idx] !== e) ? 1 : 0;
  endfunction

  task automatic check_job(input int a0, input int b0, input int r0,
                           input int fp, input int cnt, input string tag);
    int ea, eb, ia, ib, p;
    logic [7:0] lo, hi;
    ea = 0; eb = 0; ia = a0; ib = b0;
    for (int k = 0; k < cnt; k++) begin
      p  = (fp + k) % (1 << PAGE_W);
      lo = 8'(p);
      hi = 8'(p >> 8);
      ea += miss_a(ia, ent(1'b1, 1'b0, 8'h00));
      ea += miss_a(ia + 1, ent(1'b0, 1'b1, 8'h00));
      ea += miss_a(ia + 2, ent(1'b0, 1'b1, lo));
      ea += miss_a(ia + 3, ent(1'b0, 1'b1, hi));
      ia += 4;
      eb += miss_b(ib, ent(1'b1, 1'b0, 8'h80));
      eb += miss_b(ib + 1, ent(1'b0, 1'b1, 8'h00));
      eb += miss_b(ib + 2, ent(1'b0, 1'b1, lo));
      eb += miss_b(ib + 3, ent(1'b0, 1'b1, hi));
      for (int i = 0; i < PAGE_BYTES; i++)
        eb += miss_b(ib + 4 + i, ent(1'b0, 1'b0, pat(p, i)));
      eb += miss_b(ib + 4 + PAGE_BYTES, ent(1'b1, 1'b0, 8'h10));
      ib += B_PER_PAGE;
    end
    chk({tag, "_seq_a"}, ea, 0);
    chk({tag, "_len_a"}, a_log.size() - a0, 4 * cnt);
    chk({tag, "_seq_b"}, eb, 0);
    chk({tag, "_len_b"}, b_log.size() - b0, B_PER_PAGE * cnt);
    chk({tag, "_ren_a"}, ren_a_n - r0, PAGE_BYTES * cnt);
  endtask

  task automatic start_job(input int fp, input int cnt);
    @(negedge clk);
    job.start      = 1'b1;
    job.first_page = fp[PAGE_W-1:0];
    job.page_cnt   = cnt[PAGE_W:0];
    @(negedge clk);
    job.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (job.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, int'(job.done), 1);
  endtask

  task automatic check_idle_pins(input string tag);
    chk({tag, "_busy"}, int'(job.busy), 0);
    chk({tag, "_strobes"}, int'({f_wen_a, f_ren_a, f_wen_b, f_ren_b}), 15);
    chk({tag, "_latches"}, int'({f_cle_a, f_ale_a, f_cle_b, f_ale_b}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, b0, r0, n, tmp;
    logic [9:0] e;
    job.start = 1'b0;
    job.first_page = '0;
    job.page_cnt = '0;
    rb_a_busy = 5;
    rb_b_busy = 5;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_pins("reset");
    chk("reset_done", int'(job.done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single page 0
    a0 = a_log.size(); b0 = b_log.size(); r0 = ren_a_n;
    start_job(0, 1);
    chk("t1_busy_after_start", int'(job.busy), 1);
    chk("t1_done_cleared", int'(job.done), 0);
    wait_done(5000, "t1");
    chk("t1_busy_at_done", int'(job.busy), 0);
    check_job(a0, b0, r0, 0, 1, "t1");
    repeat (5) @(negedge clk);
    chk("t1_done_held", int'(job.done), 1);

    // Two pages wrapping past the top of the address space
    a0 = a_log.size(); b0 = b_log.size(); r0 = ren_a_n;
    start_job(9'h1FF, 2);
    wait_done(10000, "t2");
    check_job(a0, b0, r0, 9'h1FF, 2, "t2");
    e = a_log[a0 + 3];
    tmp = int'(e[7:0]);
    chk("t2_addr3_first", tmp, 1);
    e = a_log[a0 + 7];
    tmp = int'(e[7:0]);
    chk("t2_addr3_second", tmp, 0);

    // Zero-page job
    a0 = a_log.size(); b0 = b_log.size(); r0 = ren_a_n;
    start_job(5, 0);
    chk("t3_done_next_cycle", int'(job.done), 1);
    chk("t3_busy", int'(job.busy), 0);
    repeat (8) @(negedge clk);
    chk("t3_no_a_strobe", a_log.size() - a0, 0);
    chk("t3_no_b_strobe", b_log.size() - b0, 0);
    chk("t3_no_ren", ren_a_n - r0, 0);
    chk("t3_done_held", int'(job.done), 1);

    // R/B_A never drops (timeout path), R/B_B busy for 200 cycles
    rb_a_busy = 0;
    rb_b_busy = 200;
    a0 = a_log.size(); b0 = b_log.size(); r0 = ren_a_n;
    start_job(5, 1);
    wait_done(5000, "t4");
    check_job(a0, b0, r0, 5, 1, "t4");
    chk("t4_a_wait_timeout", b80_cyc - a3_cyc, RB_TIMEOUT + 2);
    chk("t4_b_wait_held", int'((cyc - b10_cyc) >= 200), 1);
    rb_a_busy = 5;
    rb_b_busy = 5;

    // Reset in the middle of COPY, then a clean restart
    b0 = b_log.size();
    start_job(3, 1);
    n = 0;
    while ((b_log.size() - b0) < 4 + 100 && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t5_reached_byte100", int'((b_log.size() - b0) >= 4 + 100), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_pins("t5_abort");
    chk("t5_abort_done", int'(job.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    a0 = a_log.size(); b0 = b_log.size(); r0 = ren_a_n;
    start_job(7, 1);
    wait_done(5000, "t5");
    check_job(a0, b0, r0, 7, 1, "t5");

    // start while busy with a different first_page is ignored
    a0 = a_log.size(); b0 = b_log.size(); r0 = ren_a_n;
    start_job(9'h010, 1);
    repeat (40) @(negedge clk);
    start_job(9'h020, 1);
    wait_done(5000, "t6");
    check_job(a0, b0, r0, 9'h010, 1, "t6");
    repeat (10) @(negedge clk);
    chk("t6_no_second_job", b_log.size() - b0, B_PER_PAGE);

    chk("strobe_shape_a", shape_a, 0);
    chk("strobe_shape_b", shape_b, 0);
    chk("strobe_while_rb_low_a", rbv_a, 0);
    chk("strobe_while_rb_low_b", rbv_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
